output_router: RTL and testbench



---
 rtl/tc_pkg.sv | 21 ++
 rtl/byte_fifo.sv | 79 +++++++
 rtl/output_router.sv | 111 +++++++++++
 tb/tb_output_router.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tc_pkg
// Description : Shared types and constants for the byte selector / router
//               family. Holds the byte type, the destination select encoding
//               and the default DATA_WIDTH and DEPTH values.
// Revision    : 1.0 - initial release
// ============================================================================
package tc_pkg;

    typedef logic [7:0] byte_t;

    // Destination select encoding, shared with the two-source selector
    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 2;

endpackage : tc_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Small synchronous FIFO with registered storage, wrapping
//               read/write pointers and an occupancy counter.
//               Ports:
//                 clk, rst      - clock, synchronous active-high reset
//                 i_push/i_data - write request and write data
//                 i_pop         - read request (head entry is consumed)
//                 o_data        - registered head entry
//                 o_full        - occupancy equals DEPTH
//                 o_empty       - occupancy is zero
//               Push while full and pop while empty are ignored. A push into
//               a full FIFO is refused even if a pop happens the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import tc_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_FULL_COUNT);
    assign o_empty   = (r_count == '0);
    // Full check uses the registered occupancy, so a same-cycle pop never
    // frees a slot for the push (no pass-through).
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // Storage cleared so the head reads as zero after reset
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/output_router.sv
`default_nettype none
// ============================================================================
// Module      : output_router
// Description : Steers one byte stream to two destinations, x (sel 0) and
//               y (sel 1). Each destination has its own FIFO, valid/ready
//               handshake and delivered-byte counter, so a stalled consumer
//               on one side does not block the other side.
//               Ports:
//                 clk, rst                 - clock, sync active-high reset
//                 in_valid/in_ready        - upstream handshake
//                 in_sel/in_data           - destination select and byte
//                 x_valid/x_ready/x_data   - destination x handshake
//                 y_valid/y_ready/y_data   - destination y handshake
//                 x_count/y_count          - bytes delivered since reset
// Revision    : 1.0 - initial release
// ============================================================================
module output_router
    import tc_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sel,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  x_valid,
    input  logic                  x_ready,
    output logic [DATA_WIDTH-1:0] x_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic [CNT_WIDTH-1:0]  x_count,
    output logic [CNT_WIDTH-1:0]  y_count
);

    logic w_x_full;
    logic w_x_empty;
    logic w_y_full;
    logic w_y_empty;
    logic w_x_push;
    logic w_y_push;
    logic w_x_pop;
    logic w_y_pop;

    logic [CNT_WIDTH-1:0] r_x_count;
    logic [CNT_WIDTH-1:0] r_y_count;

    // Ready depends only on the select and the registered full flags; the
    // consumer readies never reach in_ready.
    assign in_ready = (in_sel == SEL_X) ? !w_x_full : !w_y_full;

    assign w_x_push = in_valid && in_ready && (in_sel == SEL_X);
    assign w_y_push = in_valid && in_ready && (in_sel == SEL_Y);

    assign x_valid  = !w_x_empty;
    assign y_valid  = !w_y_empty;
    assign w_x_pop  = x_valid && x_ready;
    assign w_y_pop  = y_valid && y_ready;

    byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo_x (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_x_push),
        .i_data  (in_data),
        .i_pop   (w_x_pop),
        .o_data  (x_data),
        .o_full  (w_x_full),
        .o_empty (w_x_empty)
    );

    byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo_y (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_y_push),
        .i_data  (in_data),
        .i_pop   (w_y_pop),
        .o_data  (y_data),
        .o_full  (w_y_full),
        .o_empty (w_y_empty)
    );

    // Delivered-byte counters wrap naturally at 2^CNT_WIDTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_count <= '0;
            r_y_count <= '0;
        end else begin
            if (w_x_pop) begin
                r_x_count <= r_x_count + CNT_WIDTH'(1);
            end
            if (w_y_pop) begin
                r_y_count <= r_y_count + CNT_WIDTH'(1);
            end
        end
    end

    assign x_count = r_x_count;
    assign y_count = r_y_count;

endmodule : output_router
`default_nettype wire

// File: tb/tb_output_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_router
// Description : Self-checking bench for output_router. A negedge monitor
//               keeps per-destination scoreboards of accepted bytes and
//               delivered counts; scenario tasks check handshake flags,
//               head data and counters directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_router;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_sel;
    logic [DW-1:0] in_data;
    logic          x_valid;
    logic          x_ready;
    logic [DW-1:0] x_data;
    logic          y_valid;
    logic          y_ready;
    logic [DW-1:0] y_data;
    logic [CW-1:0] x_count;
    logic [CW-1:0] y_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q_x [$];
    logic [DW-1:0] q_y [$];
    logic [CW-1:0] exp_xc = '0;
    logic [CW-1:0] exp_yc = '0;

    output_router #(
        .DATA_WIDTH (DW),
        .DEPTH      (2),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_data   (x_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data),
        .x_count  (x_count),
        .y_count  (y_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: inputs and outputs are stable at the negedge and describe
    // the handshakes that happen on the following posedge.
    always @(negedge clk) begin
        if (rst) begin
            q_x.delete();
            q_y.delete();
            exp_xc = '0;
            exp_yc = '0;
        end else begin
            if (x_valid && x_ready) begin
                checks++;
                if (q_x.size() == 0) begin
                    errors++;
                    $display("FAIL sb_x: got %02h, expected nothing (queue empty)", x_data);
                end else begin
                    logic [DW-1:0] e;
                    e = q_x.pop_front();
                    if (x_data !== e) begin
                        errors++;
                        $display("FAIL sb_x: got %02h, expected %02h", x_data, e);
                    end
                end
                exp_xc = exp_xc + 1'b1;
            end
            if (y_valid && y_ready) begin
                checks++;
                if (q_y.size() == 0) begin
                    errors++;
                    $display("FAIL sb_y: got %02h, expected nothing (queue empty)", y_data);
                end else begin
                    logic [DW-1:0] e;
                    e = q_y.pop_front();
                    if (y_data !== e) begin
                        errors++;
                        $display("FAIL sb_y: got %02h, expected %02h", y_data, e);
                    end
                end
                exp_yc = exp_yc + 1'b1;
            end
            if (in_valid && in_ready) begin
                if (in_sel == 1'b0) q_x.push_back(in_data);
                else                q_y.push_back(in_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        x_ready = 1'b0;
        y_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL rst_xvalid: got %b, expected 0", x_valid); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_yvalid: got %b, expected 0", y_valid); end
        checks++; if (x_count !== 8'd0) begin errors++; $display("FAIL rst_xcount: got %0d, expected 0", x_count); end
        checks++; if (y_count !== 8'd0) begin errors++; $display("FAIL rst_ycount: got %0d, expected 0", y_count); end
        checks++; if (x_data !== 8'h00 || y_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h/%02h, expected 00/00", x_data, y_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_inready_x: got %b, expected 1", in_ready); end
        drive(1'b0, 1'b1, 8'h00);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_inready_y: got %b, expected 1", in_ready); end
    endtask

    task automatic test_basic();
        x_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h11);
        cyc();
        checks++; if (x_valid !== 1'b1 || x_data !== 8'h11) begin errors++; $display("FAIL basic_first: got v=%b d=%02h, expected v=1 d=11", x_valid, x_data); end
        drive(1'b1, 1'b0, 8'h22);
        cyc();
        checks++; if (x_valid !== 1'b1 || x_data !== 8'h22) begin errors++; $display("FAIL basic_second: got v=%b d=%02h, expected v=1 d=22", x_valid, x_data); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL basic_yvalid: got %b, expected 0", y_valid); end
        drive(1'b0, 1'b0, 8'h00);
        cyc();
        checks++; if (x_count !== 8'd2) begin errors++; $display("FAIL basic_xcount: got %0d, expected 2", x_count); end
        checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b, expected 0", x_valid); end
    endtask

    // Stalled x fills, y still accepts, then pop and refused push share a cycle
    task automatic test_stall_and_full_pop();
        x_ready = 1'b0;
        y_ready = 1'b1;
        drive(1'b1, 1'b0, 8'hA1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_a1: got in_ready=%b, expected 1", in_ready); end
        cyc();
        drive(1'b1, 1'b0, 8'hA2);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_a2: got in_ready=%b, expected 1", in_ready); end
        cyc();
        drive(1'b1, 1'b0, 8'hA3);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_a3: got in_ready=%b, expected 0", in_ready); end
        cyc();
        checks++; if (x_data !== 8'hA1) begin errors++; $display("FAIL stall_hold: got %02h, expected a1", x_data); end
        drive(1'b1, 1'b1, 8'hB1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_y_ready: got in_ready=%b, expected 1", in_ready); end
        cyc();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'hB1) begin errors++; $display("FAIL stall_b1: got v=%b d=%02h, expected v=1 d=b1", y_valid, y_data); end
        // x full, pop and push offered in the same cycle: push must be refused
        x_ready = 1'b1;
        drive(1'b1, 1'b0, 8'hA3);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_refuse: got in_ready=%b, expected 0", in_ready); end
        cyc();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_next: got in_ready=%b, expected 1", in_ready); end
        checks++; if (x_data !== 8'hA2) begin errors++; $display("FAIL fullpop_head: got %02h, expected a2", x_data); end
        cyc();
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (x_data !== 8'hA3) begin errors++; $display("FAIL stall_a3_out: got %02h, expected a3", x_data); end
        cyc();
        cyc();
        checks++; if (x_count !== exp_xc || y_count !== exp_yc) begin errors++; $display("FAIL stall_counts: got %0d/%0d, expected %0d/%0d", x_count, y_count, exp_xc, exp_yc); end
        checks++; if (x_valid !== 1'b0 || y_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b/%b, expected 0/0", x_valid, y_valid); end
    endtask

    task automatic test_interleave();
        logic [CW-1:0] bx;
        logic [CW-1:0] by;
        bx = x_count;
        by = y_count;
        x_ready = 1'b1;
        y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[0], 8'(i + 1));
            cyc();
        end
        drive(1'b0, 1'b0, 8'h00);
        cyc();
        cyc();
        checks++; if (x_count !== bx + 8'd2) begin errors++; $display("FAIL inter_xcount: got %0d, expected %0d", x_count, bx + 8'd2); end
        checks++; if (y_count !== by + 8'd2) begin errors++; $display("FAIL inter_ycount: got %0d, expected %0d", y_count, by + 8'd2); end
    endtask

    task automatic test_reset_mid();
        x_ready = 1'b0;
        y_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i >= 2), 8'(8'hC0 + i));
            cyc();
        end
        checks++; if (x_count === 8'd0 || y_count === 8'd0) begin errors++; $display("FAIL mid_pre: got counts %0d/%0d, expected non-zero", x_count, y_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got in_ready=%b, expected 0", in_ready); end
        // Handshakes would occur on both ports this cycle were it not for rst
        x_ready = 1'b1;
        y_ready = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (x_valid !== 1'b0 || y_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b/%b, expected 0/0", x_valid, y_valid); end
        checks++; if (x_count !== 8'd0 || y_count !== 8'd0) begin errors++; $display("FAIL mid_count: got %0d/%0d, expected 0/0", x_count, y_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_inready: got %b, expected 1", in_ready); end
        cyc();
        checks++; if (x_count !== 8'd0 || y_count !== 8'd0) begin errors++; $display("FAIL mid_nohs: got %0d/%0d, expected 0/0", x_count, y_count); end
    endtask

    task automatic test_wrap();
        x_ready = 1'b1;
        y_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 1'b1, 8'(i * 7));
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: beat %0d got %b, expected 1", i, in_ready); end
            cyc();
        end
        drive(1'b0, 1'b0, 8'h00);
        cyc();
        cyc();
        checks++; if (y_count !== 8'd1) begin errors++; $display("FAIL wrap_ycount: got %0d, expected 1", y_count); end
        checks++; if (x_count !== 8'd0) begin errors++; $display("FAIL wrap_xcount: got %0d, expected 0", x_count); end
        checks++; if (q_x.size() != 0 || q_y.size() != 0) begin errors++; $display("FAIL wrap_leftover: got %0d/%0d queued, expected 0/0", q_x.size(), q_y.size()); end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        x_ready  = 1'b0;
        y_ready  = 1'b0;
        test_reset();
        test_basic();
        test_stall_and_full_pop();
        test_interleave();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_output_router
`default_nettype wire
